// File: rtl/fp_pkg.sv
// Shared types and constants for the FP adder issue controller.
package fp_pkg;

  typedef struct packed {
    logic       sign;
    logic [7:0] exp;
    logic [22:0] frac;
  } fp32_t;

  localparam logic [31:0] FP_QNAN = 32'h7FFF_FFFF;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} issue_state_t;

endpackage

// File: rtl/fp_add_issue_if.sv
// Request stream, adder pins and result stream of the FP adder issue controller.
// out_err exists only when FP_ISSUE_TIMEOUT_EN is defined.
interface fp_add_issue_if #(
  parameter int TAG_W = 4
);
  import fp_pkg::*;

  logic             in_valid;
  logic             in_ready;
  fp32_t            in_a;
  fp32_t            in_b;
  logic             in_op;
  logic [TAG_W-1:0] in_tag;

  logic             add_start;
  fp32_t            add_a;
  fp32_t            add_b;
  logic             add_op;
  logic             add_busy;
  logic             add_ready;
  fp32_t            add_y;

  logic             out_valid;
  logic             out_ready;
  fp32_t            out_y;
  logic [TAG_W-1:0] out_tag;
`ifdef FP_ISSUE_TIMEOUT_EN
  logic             out_err;
`endif

  modport slave (
`ifdef FP_ISSUE_TIMEOUT_EN
    output out_err,
`endif
    input  in_valid, in_a, in_b, in_op, in_tag,
    output in_ready,
    output add_start, add_a, add_b, add_op,
    input  add_busy, add_ready, add_y,
    output out_valid, out_y, out_tag,
    input  out_ready
  );

  modport master (
`ifdef FP_ISSUE_TIMEOUT_EN
    input  out_err,
`endif
    output in_valid, in_a, in_b, in_op, in_tag,
    input  in_ready,
    input  add_start, add_a, add_b, add_op,
    output add_busy, add_ready, add_y,
    input  out_valid, out_y, out_tag,
    output out_ready
  );

endinterface

// File: rtl/fp_req_fifo.sv
// Synchronous FIFO with asynchronous reset; pointers carry an extra wrap bit.
module fp_req_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop && !empty) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage needs no reset: the pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  assign rdata = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/fp_add_issue.sv
// Queues tagged add/sub requests and serialises them to a multi-cycle FP adder.
// Optional watchdog on the adder completion: define FP_ISSUE_TIMEOUT_EN.
module fp_add_issue
  import fp_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 64
) (
  input logic           clk,
  input logic           rst,
  fp_add_issue_if.slave bus
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("fp_add_issue: DEPTH must be a power of two >= 2");
  end
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("fp_add_issue: TIMEOUT must fit the 8-bit wait counter");
  end

  typedef struct packed {
    fp32_t            a;
    fp32_t            b;
    logic             op;
    logic [TAG_W-1:0] tag;
  } req_t;

  req_t             in_req;
  req_t             head;
  logic             fifo_full;
  logic             fifo_empty;
  issue_state_t     state_q;
  issue_state_t     state_d;
  logic             start;
  logic             capture;
  fp32_t            cap_y;
  logic             out_valid_q;
  fp32_t            out_y_q;
  logic [TAG_W-1:0] out_tag_q;

  assign in_req = {bus.in_a, bus.in_b, bus.in_op, bus.in_tag};

  // The head stays in the queue until its result is captured, so it doubles as the operand hold register.
  fp_req_fifo #(
    .WIDTH ($bits(req_t)),
    .DEPTH (DEPTH)
  ) u_req_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.in_valid && !fifo_full),
    .pop   (capture),
    .wdata (in_req),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

`ifdef FP_ISSUE_TIMEOUT_EN
  logic [7:0] wait_cnt;
  logic       cap_err;
  logic       out_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (state_q != WAIT) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    capture = 1'b0;
    cap_y   = bus.add_y;
`ifdef FP_ISSUE_TIMEOUT_EN
    cap_err = 1'b0;
`endif
    case (state_q)
      // A stale busy adder (e.g. after a reset mid-operation) blocks the next issue.
      IDLE: begin
        if (!fifo_empty && (!out_valid_q || bus.out_ready) && !bus.add_busy) state_d = ISSUE;
      end
      ISSUE: begin
        start   = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        if (bus.add_ready) begin
          capture = 1'b1;
          state_d = IDLE;
        end
`ifdef FP_ISSUE_TIMEOUT_EN
        else if (wait_cnt == 8'(TIMEOUT - 1)) begin
          capture = 1'b1;
          cap_y   = FP_QNAN;
          cap_err = 1'b1;
          state_d = IDLE;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_y_q     <= '0;
      out_tag_q   <= '0;
    end else if (capture) begin
      out_valid_q <= 1'b1;
      out_y_q     <= cap_y;
      out_tag_q   <= head.tag;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

`ifdef FP_ISSUE_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_err_q <= 1'b0;
    end else if (capture) begin
      out_err_q <= cap_err;
    end
  end

  assign bus.out_err = out_err_q;
`endif

  assign bus.in_ready  = !fifo_full;
  assign bus.add_start = start;
  assign bus.add_a     = head.a;
  assign bus.add_b     = head.b;
  assign bus.add_op    = head.op;
  assign bus.out_valid = out_valid_q;
  assign bus.out_y     = out_y_q;
  assign bus.out_tag   = out_tag_q;

endmodule

// File: tb/tb_fp_add_issue.sv
// Scoreboard bench for fp_add_issue driving a latency-programmable adder model.
// Define FP_ISSUE_TIMEOUT_EN to also exercise the watchdog path.
module tb_fp_add_issue;
  import fp_pkg::*;

  localparam int DEPTH   = 4;
  localparam int TAG_W   = 4;
  localparam int TIMEOUT = 16;

  localparam logic [31:0] VA [6] = '{32'h3F800000, 32'h3F800000, 32'h40000000,
                                     32'h40800000, 32'h40400000, 32'h40A00000};
  localparam logic [31:0] VB [6] = '{32'h3F800000, 32'h40000000, 32'h40000000,
                                     32'h3F800000, 32'h3F800000, 32'h3F800000};
  localparam logic        VOP [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  localparam logic [31:0] VY [6] = '{32'h40000000, 32'h40400000, 32'h40800000,
                                     32'h40400000, 32'h40800000, 32'h40800000};

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        op;
    logic [31:0] y;
  } op_t;

  typedef struct {
    logic [31:0]      y;
    logic [TAG_W-1:0] tag;
    logic             err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  op_t  model_q [$];
  exp_t sb_q [$];
  op_t  cur;
  exp_t mon_e;
  int   cnt;
  int   n_compared   = 0;
  int   n_mismatched = 0;
  int   lat          = 3;
  bit   hang         = 1'b0;
  bit   outstanding  = 1'b0;
  bit   stale        = 1'b0;

  fp_add_issue_if #(.TAG_W(TAG_W)) bus ();

  fp_add_issue #(
    .DEPTH   (DEPTH),
    .TAG_W   (TAG_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] required);
    n_compared++;
    if (actual !== required) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, required);
    end
  endtask

  // Queues the adder-model entry and, unless the request is to be discarded, the expected result.
  task automatic apply_stimulus(input logic [31:0] a, input logic [31:0] b, input logic op,
                                input logic [TAG_W-1:0] tag, input logic [31:0] y,
                                input logic err, input bit expect_out);
    bit accepted = 1'b0;
    model_q.push_back('{a, b, op, y});
    if (expect_out) sb_q.push_back('{y, tag, err});
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_op    = op;
    bus.in_tag   = tag;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 200 && !accepted; i++) begin
      @(negedge clk);
      accepted = bus.in_ready;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    check_output("push_accepted", 32'(accepted), 32'd1);
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int i = 0; i < 500 && !done; i++) begin
      @(negedge clk);
      done = (sb_q.size() == 0) && (model_q.size() == 0) && !outstanding;
    end
    check_output("drain_done", 32'(done), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic measure_latency(input string name, input int required);
    int n = 0;
    while (!bus.out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_output(name, 32'(n), 32'(required));
  endtask

  // Adder model: takes operands on add_start, answers add_ready after lat cycles unless hung.
  initial begin
    bus.add_busy  = 1'b0;
    bus.add_ready = 1'b0;
    bus.add_y     = '0;
    forever begin
      @(negedge clk);
      bus.add_ready = 1'b0;
      if (bus.add_start) begin
        check_output("start_overlap", 32'(outstanding), 32'd0);
        if (model_q.size() == 0) begin
          n_compared++;
          n_mismatched++;
          $display("[TB] FAIL unexpected_start: got add_start=1, expected no issue");
        end else begin
          cur = model_q.pop_front();
          check_output("issue_a", bus.add_a, cur.a);
          check_output("issue_b", bus.add_b, cur.b);
          check_output("issue_op", 32'(bus.add_op), 32'(cur.op));
          cnt = 0;
          if (!hang) begin
            outstanding  = 1'b1;
            bus.add_busy = 1'b1;
          end
        end
      end else if (outstanding) begin
        cnt++;
        if (!stale) begin
          check_output("hold_a", bus.add_a, cur.a);
          check_output("hold_b", bus.add_b, cur.b);
          check_output("hold_op", 32'(bus.add_op), 32'(cur.op));
        end
        if (cnt >= lat) begin
          bus.add_ready = 1'b1;
          bus.add_y     = cur.y;
          bus.add_busy  = 1'b0;
          outstanding   = 1'b0;
          stale         = 1'b0;
        end
      end
    end
  end

  // Monitor: every accepted result is matched against the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (sb_q.size() == 0) begin
        n_compared++;
        n_mismatched++;
        $display("[TB] FAIL unexpected_result: got y=%h tag=%0d, expected no result", bus.out_y, bus.out_tag);
      end else begin
        mon_e = sb_q.pop_front();
        check_output("out_y", bus.out_y, mon_e.y);
        check_output("out_tag", 32'(bus.out_tag), 32'(mon_e.tag));
`ifdef FP_ISSUE_TIMEOUT_EN
        check_output("out_err", 32'(bus.out_err), 32'(mon_e.err));
`endif
      end
    end
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_op     = 1'b0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    check_output("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check_output("rst_add_start", 32'(bus.add_start), 32'd0);
    check_output("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_output("rst_out_y", bus.out_y, 32'd0);
    check_output("rst_out_tag", 32'(bus.out_tag), 32'd0);
`ifdef FP_ISSUE_TIMEOUT_EN
    check_output("rst_out_err", 32'(bus.out_err), 32'd0);
`endif
    @(posedge clk);
    #1 rst = 1'b0;

    $display("[TB] single add");
    bus.out_ready = 1'b1;
    lat = 3;
    apply_stimulus(32'h3F800000, 32'h40000000, 1'b0, 4'd3, 32'h40400000, 1'b0, 1'b1);
    measure_latency("single_latency", lat + 3);
    wait_idle();

    $display("[TB] subtract ordering");
    apply_stimulus(32'h40A00000, 32'h3F800000, 1'b1, 4'd1, 32'h40800000, 1'b0, 1'b1);
    apply_stimulus(32'h3F800000, 32'h3F800000, 1'b0, 4'd2, 32'h40000000, 1'b0, 1'b1);
    wait_idle();

    $display("[TB] back-pressure");
    bus.out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      apply_stimulus(VA[k], VB[k], VOP[k], TAG_W'(k), VY[k], 1'b0, 1'b1);
    end
    repeat (3) @(negedge clk);
    check_output("bp_in_ready", 32'(bus.in_ready), 32'd0);
    check_output("bp_out_valid", 32'(bus.out_valid), 32'd1);
    check_output("bp_out_tag", 32'(bus.out_tag), 32'd0);
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    wait_idle();

    $display("[TB] simultaneous drain and capture");
    lat = 2;
    for (int k = 0; k < 6; k++) begin
      apply_stimulus(VA[k], VB[k], VOP[k], TAG_W'(8 + k), VY[k], 1'b0, 1'b1);
    end
    wait_idle();

    $display("[TB] reset during wait");
    lat = 3;
    apply_stimulus(32'h3F800000, 32'h3F800000, 1'b0, 4'd5, 32'h40000000, 1'b0, 1'b0);
    for (int i = 0; i < 50 && !outstanding; i++) @(negedge clk);
    check_output("reset_op_started", 32'(outstanding), 32'd1);
    @(posedge clk);
    #1;
    stale = outstanding;
    rst   = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check_output("post_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_output("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    apply_stimulus(32'h40000000, 32'h40000000, 1'b0, 4'd6, 32'h40800000, 1'b0, 1'b1);
    wait_idle();

`ifdef FP_ISSUE_TIMEOUT_EN
    $display("[TB] watchdog");
    hang = 1'b1;
    apply_stimulus(32'h3F800000, 32'h40000000, 1'b0, 4'd7, 32'h7FFFFFFF, 1'b1, 1'b1);
    measure_latency("timeout_latency", TIMEOUT + 3);
    wait_idle();
    hang = 1'b0;
    lat  = 2;
    apply_stimulus(32'h40400000, 32'h3F800000, 1'b0, 4'd9, 32'h40800000, 1'b0, 1'b1);
    wait_idle();
`endif

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  initial begin
    #500000;
    n_mismatched++;
    $display("[TB] FAIL global_timeout: got no completion, expected finish within bound");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $fatal(1, "[TB] simulation bound expired");
  end

endmodule
